// File: rtl/itim_assoc_if.sv
// Fetch/memory bus used on both sides of itim_assoc.
// Handshake: the master raises mem_valid with mem_addr/mem_fence; the slave
// answers with a single-cycle mem_ready pulse carrying mem_rdata (mem_rdata is
// 0 whenever mem_ready is 0). There is no back-pressure on the response.
interface itim_assoc_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_fence;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_fence, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_fence, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/itim_assoc.sv
// itim_assoc: N-way set-associative instruction TIM between the fetch unit
// (itim, slave side) and the instruction memory (imem, master side).
// Hits answer one cycle after the request; misses refill one word; addresses
// outside [BASE_ADDR, TOP_ADDR) bypass without allocating; a fence clears
// every valid bit and then acknowledges with rdata 0.
// Optional macro ITIM_PLRU_EN: per-set round-robin victim pointers instead of
// a single global fill counter.
module itim_assoc #(
  parameter int          WAYS      = 2,
  parameter int          SETS      = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] TOP_ADDR  = 32'h0001_0000
) (
  input  logic         clock,
  input  logic         reset,
  itim_assoc_if.slave  itim,
  itim_assoc_if.master imem,
  output logic [1:0]   dbg_state
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [IDX_W:0] SWEEP_END = (IDX_W + 1)'(SETS);

  typedef enum logic [1:0] {IDLE, MISS, LOAD, FENCE} state_t;

  state_t          state;
  logic            req_pend;
  logic            req_fence;
  logic [31:0]     req_addr;
  logic [IDX_W:0]  sweep_cnt;

  logic [WAYS-1:0]  valid_q  [SETS];
  logic [TAG_W-1:0] tag_ram  [WAYS][SETS];
  logic [31:0]      data_ram [WAYS][SETS];
  logic [TAG_W-1:0] rd_tag   [WAYS];
  logic [31:0]      rd_data  [WAYS];

`ifdef ITIM_PLRU_EN
  logic [WAY_W-1:0] rr_ptr [SETS];
`else
  logic [WAY_W-1:0] fill_cnt;
`endif

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] in_idx;
  logic [32:0]      lo_diff;
  logic [32:0]      hi_diff;
  logic             out_win;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [31:0]      hit_data;
  logic [WAY_W-1:0] victim;
  logic             lookup, lk_fence, lk_bypass, lk_hit, lk_miss;
  logic             accept, fill_done, load_done, fence_done;

  assign req_idx = req_addr[IDX_W+1:2];
  assign req_tag = req_addr[31:IDX_W+2];
  assign in_idx  = itim.mem_addr[IDX_W+1:2];

  // 33-bit differences give the window test without constant-compare corner cases
  assign lo_diff = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign hi_diff = {1'b0, req_addr} - {1'b0, TOP_ADDR};
  assign out_win = lo_diff[32] | ~hi_diff[32];

  function automatic logic [WAY_W-1:0] ptr_next(input logic [WAY_W-1:0] p);
    if (WAYS == 1) return '0;
    return p + 1'b1;
  endfunction

  // Tag compare across all ways plus victim choice for the pending set
  always_comb begin
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (rd_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    hit_data = rd_data[hit_way];
`ifdef ITIM_PLRU_EN
    victim = inv_found ? inv_way : rr_ptr[req_idx];
`else
    victim = inv_found ? inv_way : fill_cnt;
`endif
  end

  assign lookup     = (state == IDLE) && req_pend;
  assign lk_fence   = lookup && req_fence;
  assign lk_bypass  = lookup && !req_fence && out_win;
  assign lk_hit     = lookup && !req_fence && !out_win && hit;
  assign lk_miss    = lookup && !req_fence && !out_win && !hit;
  // A hit frees the lookup slot, so a new request may be taken in the same cycle
  assign accept     = (state == IDLE) && itim.mem_valid && (!req_pend || lk_hit);
  assign fill_done  = (state == MISS) && imem.mem_ready;
  assign load_done  = (state == LOAD) && imem.mem_ready;
  assign fence_done = (state == FENCE) && (sweep_cnt == SWEEP_END);

  assign itim.mem_ready = lk_hit | fill_done | load_done | fence_done;
  assign itim.mem_rdata = lk_hit                  ? hit_data       :
                          (fill_done | load_done) ? imem.mem_rdata : 32'h0;

  assign imem.mem_valid = lk_bypass | lk_miss | (state == MISS) | (state == LOAD);
  assign imem.mem_addr  = imem.mem_valid ? req_addr : 32'h0;
  assign imem.mem_instr = 1'b1;
  assign imem.mem_fence = 1'b0;
  assign imem.mem_wdata = 32'h0;
  assign imem.mem_wstrb = 4'h0;

  assign dbg_state = state;

  wire unused_bits = ^{itim.mem_instr, itim.mem_wdata, itim.mem_wstrb, req_addr[1:0]};

  // Control FSM: request capture, lookup outcome, refill wait, fence sweep
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      req_pend  <= 1'b0;
      req_fence <= 1'b0;
      req_addr  <= 32'h0;
      sweep_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lk_fence) begin
            state     <= FENCE;
            sweep_cnt <= '0;
          end else if (lk_bypass) begin
            state <= LOAD;
          end else if (lk_miss) begin
            state <= MISS;
          end
          if (accept) begin
            req_pend  <= 1'b1;
            req_fence <= itim.mem_fence;
            req_addr  <= itim.mem_addr;
          end else if (lookup) begin
            req_pend <= 1'b0;
          end
        end
        MISS, LOAD: begin
          if (imem.mem_ready) state <= IDLE;
        end
        FENCE: begin
          if (fence_done) state <= IDLE;
          else sweep_cnt <= sweep_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits and replacement state
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
`ifdef ITIM_PLRU_EN
        rr_ptr[s] <= '0;
`endif
      end
`ifndef ITIM_PLRU_EN
      fill_cnt <= '0;
`endif
    end else begin
      if (fill_done) valid_q[req_idx][victim] <= 1'b1;
      if ((state == FENCE) && !fence_done) valid_q[sweep_cnt[IDX_W-1:0]] <= '0;
`ifdef ITIM_PLRU_EN
      if (fill_done) rr_ptr[req_idx] <= ptr_next(victim);
      else if (lk_hit) rr_ptr[req_idx] <= ptr_next(hit_way);
`else
      if (fill_done) fill_cnt <= ptr_next(fill_cnt);
`endif
    end
  end

  // Tag/data RAMs: write on refill, registered read addressed by the accepted request
  always_ff @(posedge clock) begin
    if (fill_done) begin
      tag_ram[victim][req_idx]  <= req_tag;
      data_ram[victim][req_idx] <= imem.mem_rdata;
    end
    if (accept) begin
      for (int w = 0; w < WAYS; w++) begin
        rd_tag[w]  <= tag_ram[w][in_idx];
        rd_data[w] <= data_ram[w][in_idx];
      end
    end
  end

endmodule

// File: tb/tb_itim_assoc.sv
// Directed bench for itim_assoc (WAYS=2, SETS=64). Driver tasks issue fetches
// and act as the instruction memory; expected read data goes into exp_q and a
// monitor pops it whenever the DUT pulses itim mem_ready.
module tb_itim_assoc;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  itim_assoc_if itim_bus ();
  itim_assoc_if imem_bus ();

  itim_assoc #(
    .WAYS(2), .SETS(64), .BASE_ADDR(32'h0), .TOP_ADDR(32'h0001_0000)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .itim      (itim_bus),
    .imem      (imem_bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset) begin
      if (itim_bus.mem_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          check("rdata", itim_bus.mem_rdata, exp_q.pop_front());
        end
      end else begin
        check("rdata_idle_zero", itim_bus.mem_rdata, 32'h0);
      end
    end
  end

  // Single fetch; exp_mem=1 means a refill/bypass is expected and served 3 cycles on
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input bit exp_mem);
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b1;
    itim_bus.mem_fence = 1'b0;
    itim_bus.mem_addr  = addr;
    exp_q.push_back(word);
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b0;
    @(negedge clock);
    if (exp_mem) begin
      check("imem_req_valid", {31'h0, imem_bus.mem_valid}, 32'd1);
      check("imem_req_addr", imem_bus.mem_addr, addr);
      check("miss_no_early_ready", {31'h0, itim_bus.mem_ready}, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      imem_bus.mem_ready = 1'b1;
      imem_bus.mem_rdata = word;
      @(negedge clock);
      check("imem_hold_addr", imem_bus.mem_addr, addr);
      check("refill_ready", {31'h0, itim_bus.mem_ready}, 32'd1);
      @(posedge clock); #1;
      imem_bus.mem_ready = 1'b0;
      imem_bus.mem_rdata = 32'h0;
    end else begin
      check("hit_ready", {31'h0, itim_bus.mem_ready}, 32'd1);
      check("hit_no_imem", {31'h0, imem_bus.mem_valid}, 32'd0);
    end
  endtask

  // Two hits requested in consecutive cycles
  task automatic fetch_b2b(input logic [31:0] a, input logic [31:0] da,
                           input logic [31:0] b, input logic [31:0] db);
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b1;
    itim_bus.mem_addr  = a;
    exp_q.push_back(da);
    @(posedge clock); #1;
    itim_bus.mem_addr = b;
    exp_q.push_back(db);
    @(negedge clock);
    check("b2b_first_ready", {31'h0, itim_bus.mem_ready}, 32'd1);
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b0;
    @(negedge clock);
    check("b2b_second_ready", {31'h0, itim_bus.mem_ready}, 32'd1);
    check("b2b_no_imem", {31'h0, imem_bus.mem_valid}, 32'd0);
  endtask

  task automatic fence();
    int n;
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b1;
    itim_bus.mem_fence = 1'b1;
    itim_bus.mem_addr  = 32'h0;
    exp_q.push_back(32'h0);
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b0;
    itim_bus.mem_fence = 1'b0;
    @(negedge clock);
    n = 0;
    while (itim_bus.mem_ready !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("fence_latency", n, 32'd65);
    @(posedge clock); #1;
  endtask

  initial begin
    itim_bus.mem_valid = 1'b0;
    itim_bus.mem_fence = 1'b0;
    itim_bus.mem_instr = 1'b1;
    itim_bus.mem_addr  = 32'h0;
    itim_bus.mem_wdata = 32'h0;
    itim_bus.mem_wstrb = 4'h0;
    imem_bus.mem_ready = 1'b0;
    imem_bus.mem_rdata = 32'h0;

    // Reset
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ready", {31'h0, itim_bus.mem_ready}, 32'd0);
    check("rst_imem_valid", {31'h0, imem_bus.mem_valid}, 32'd0);
    check("rst_imem_addr", imem_bus.mem_addr, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'd0);

    // Miss then hit
    fetch(32'h100, 32'h0000_0013, 1'b1);
    fetch(32'h100, 32'h0000_0013, 1'b0);

    // Set conflict in set 0
    fetch(32'h200, 32'h0000_00b2, 1'b1);
`ifdef ITIM_PLRU_EN
    fetch(32'h100, 32'h0000_0013, 1'b0);
    fetch(32'h300, 32'h0000_00c3, 1'b1);
    fetch(32'h100, 32'h0000_0013, 1'b0);
    fetch(32'h200, 32'h0000_00b2, 1'b1);
`else
    fetch(32'h300, 32'h0000_00c3, 1'b1);
    fetch(32'h200, 32'h0000_00b2, 1'b0);
    fetch(32'h100, 32'h0000_0013, 1'b1);
`endif

    // Back-to-back hits in set 1
    fetch(32'h104, 32'h1111_0104, 1'b1);
    fetch(32'h204, 32'h2222_0204, 1'b1);
    fetch_b2b(32'h104, 32'h1111_0104, 32'h204, 32'h2222_0204);

    // Bypass window edges
    fetch(32'h1_0000, 32'h0000_00aa, 1'b1);
    fetch(32'h1_0000, 32'h0000_00bb, 1'b1);
    fetch(32'h0_fffc, 32'h0000_00cc, 1'b1);
    fetch(32'h0_fffc, 32'h0000_00cc, 1'b0);

    // Fence clears everything
    fence();
    fetch(32'h200, 32'h0000_00b2, 1'b1);
    fetch(32'h0_fffc, 32'h0000_00cc, 1'b1);

    // Reset while a miss is outstanding
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b1;
    itim_bus.mem_addr  = 32'h104;
    @(posedge clock); #1;
    itim_bus.mem_valid = 1'b0;
    @(negedge clock);
    check("mid_miss_req", {31'h0, imem_bus.mem_valid}, 32'd1);
    @(posedge clock); #1;
    check("mid_miss_state", {30'h0, dbg_state}, 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_imem_valid", {31'h0, imem_bus.mem_valid}, 32'd0);
    check("post_rst_imem_addr", imem_bus.mem_addr, 32'h0);
    @(posedge clock); #1;
    imem_bus.mem_ready = 1'b1;
    imem_bus.mem_rdata = 32'hdead_beef;
    @(negedge clock);
    check("late_ready_ignored", {31'h0, itim_bus.mem_ready}, 32'd0);
    @(posedge clock); #1;
    imem_bus.mem_ready = 1'b0;
    imem_bus.mem_rdata = 32'h0;
    fetch(32'h100, 32'h0000_0013, 1'b1);

    repeat (3) @(posedge clock);
    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
